// File: rtl/apb_reg_pkg.sv
// apb_reg_pkg: shared widths, the completer state type and a range helper for
// the APB register completer.
//   ADDR_W / DATA_W : APB address and data widths (8 bits each)
//   WAIT_W          : width of the wait-state counter (0..15 wait states)
//   state_t         : IDLE / ACCESS
//   in_range()      : true when an address selects an implemented register
package apb_reg_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int WAIT_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a, input int n);
        return int'(a) < n;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: bank of NUM_REGS 8-bit registers with one synchronous write
// port and one combinational read port. Out-of-range writes are dropped and
// out-of-range reads return 0x00.
//   pclk    : clock
//   prst    : asynchronous active-low reset, clears every register
//   we      : write enable
//   wr_idx  : register index written when we=1
//   wr_data : write data
//   rd_idx  : register index read
//   rd_data : read data (combinational)
module apb_reg_bank
    import apb_reg_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && in_range(wr_idx, NUM_REGS)) begin
            regs[wr_idx[IDX_W-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range(rd_idx, NUM_REGS)) begin
            rd_data = regs[rd_idx[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB completer in front of an 8-bit register bank.
// Captures address/direction/data on the setup edge, inserts WAIT_CYCLES wait
// states via a registered pready, then commits the write or returns read data.
//   pclk, prst      : clock, asynchronous active-low reset
//   psel, pen       : APB select / enable
//   pwrite          : 1 = write, 0 = read
//   paddr, pwdata   : APB address and write data
//   prdata          : read data, valid while pready=1 on a read
//   pready          : registered, high for exactly one cycle per transfer
//   wr_strobe       : one-cycle pulse after a write commits
//   wr_idx          : index of the register last committed
//   pslverr         : only with APB_REG_SLVERR_EN; error alongside pready
// Optional feature macro: APB_REG_SLVERR_EN. When defined, register
// NUM_REGS-1 is a read-only saturating count of aborted transfers and
// pslverr flags out-of-range accesses and writes to that register.
module apb_reg_completer
    import apb_reg_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              pen,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_idx
`ifdef APB_REG_SLVERR_EN
    ,
    output logic              pslverr
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LD    = WAIT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_write;

    logic              active;
    logic              setup;
    logic              done;
    logic              abort;
    logic              cap_err;
    logic              commit;

    logic              bank_we;
    logic [ADDR_W-1:0] bank_wr_idx;
    logic [DATA_W-1:0] bank_wr_data;
    logic [ADDR_W-1:0] bank_rd_idx;
    logic [DATA_W-1:0] bank_rd_data;

    assign active = psel && pen;
    assign setup  = (state == IDLE) && psel && !pen;
    assign done   = (state == ACCESS) && active && pready;
    assign abort  = (state == ACCESS) && !active;

`ifdef APB_REG_SLVERR_EN
    logic setup_err;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + DATA_W'(1);
    endfunction

    // The status register is read-only from the bus.
    assign setup_err = !in_range(paddr, NUM_REGS) || (pwrite && paddr == STATUS_IDX);
    assign cap_err   = !in_range(cap_addr, NUM_REGS) || (cap_write && cap_addr == STATUS_IDX);

    // An abort reuses the single write port to bump the status counter;
    // it can never coincide with a committing write.
    assign bank_we      = commit || abort;
    assign bank_wr_idx  = abort ? STATUS_IDX : cap_addr;
    assign bank_wr_data = abort ? sat_inc(bank_rd_data) : cap_wdata;
    assign bank_rd_idx  = (state == IDLE) ? paddr : (abort ? STATUS_IDX : cap_addr);
`else
    assign cap_err      = !in_range(cap_addr, NUM_REGS);
    assign bank_we      = commit;
    assign bank_wr_idx  = cap_addr;
    assign bank_wr_data = cap_wdata;
    // In IDLE the live address feeds the zero-wait read on the setup edge.
    assign bank_rd_idx  = (state == IDLE) ? paddr : cap_addr;
`endif

    assign commit = done && cap_write && !cap_err;

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .pclk    (pclk),
        .prst    (prst),
        .we      (bank_we),
        .wr_idx  (bank_wr_idx),
        .wr_data (bank_wr_data),
        .rd_idx  (bank_rd_idx),
        .rd_data (bank_rd_data)
    );

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
            pready    <= 1'b0;
            prdata    <= '0;
            wr_strobe <= 1'b0;
            wr_idx    <= '0;
`ifdef APB_REG_SLVERR_EN
            pslverr   <= 1'b0;
`endif
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup) begin
                        cap_addr  <= paddr;
                        cap_write <= pwrite;
                        cap_wdata <= pwdata;
                        wait_cnt  <= WAIT_LD;
                        state     <= ACCESS;
                        if (WAIT_CYCLES == 0) begin
                            pready <= 1'b1;
                            prdata <= pwrite ? '0 : bank_rd_data;
`ifdef APB_REG_SLVERR_EN
                            pslverr <= setup_err;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (!active) begin
                        state  <= IDLE;
                        pready <= 1'b0;
                        prdata <= '0;
`ifdef APB_REG_SLVERR_EN
                        pslverr <= 1'b0;
`endif
                    end else if (pready) begin
                        state  <= IDLE;
                        pready <= 1'b0;
                        prdata <= '0;
`ifdef APB_REG_SLVERR_EN
                        pslverr <= 1'b0;
`endif
                        if (commit) begin
                            wr_strobe <= 1'b1;
                            wr_idx    <= cap_addr;
                        end
                    end else begin
                        // Counter holds the wait states still to go; pready is
                        // raised on the edge that consumes the last one.
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(1)) begin
                            pready <= 1'b1;
                            prdata <= cap_write ? '0 : bank_rd_data;
`ifdef APB_REG_SLVERR_EN
                            pslverr <= cap_err;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_reg_completer.md
# apb_reg_completer

APB completer (slave) that answers the transfers the bus initiator drives on the 8-bit APB interface. It holds a bank of 8-bit registers, inserts a configurable number of wait states through `pready`, and commits writes / returns read data on completion. It sits behind the APB interconnect as the responding end, and is the block the bus protocol checkers observe.

## Interface
- `NUM_REGS`, 16: number of 8-bit registers; legal addresses are 0 .. NUM_REGS-1 (max 256).
- `WAIT_CYCLES`, 0: wait states inserted in the access phase before `pready` rises (0..15).
- `pclk`  in  1  single clock; all logic on its rising edge.
- `prst`  in  1  asynchronous, active-low reset.
- `psel`  in  1  completer select.
- `pen`  in  1  enable; high marks the access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  8  register address.
- `pwdata`  in  8  write data.
- `prdata`  out  8  read data; valid only while `pready`=1 on a read.
- `pready`  out  1  transfer completes on the edge where `psel`&`pen`&`pready`=1.
- `pslverr`  out  1  present only with `APB_REG_SLVERR_EN`.
- `wr_strobe`  out  1  one-cycle pulse when a write commits.
- `wr_idx`  out  8  register index written; valid with `wr_strobe`.

## Operation
- States: IDLE, ACCESS.
- IDLE: on an edge sampling `psel`=1, `pen`=0 (setup), capture `paddr`, `pwrite`, `pwdata`. Load wait counter with WAIT_CYCLES and go to ACCESS. `pready` <= (WAIT_CYCLES==0). For a read with WAIT_CYCLES==0, `prdata` <= reg[addr] on the same edge.
- IDLE with `psel`=1, `pen`=1 (no setup seen): ignored, stay IDLE.
- ACCESS, `psel`&`pen`=1, `pready`=0: decrement counter. When it reaches the last wait cycle, `pready` <= 1 and, for a read, `prdata` <= reg[captured addr].
- ACCESS, `psel`&`pen`&`pready`=1: transfer completes. A write commits captured `pwdata` to reg[captured addr], and `wr_strobe`=1 and `wr_idx` are registered on this edge. `pready` <= 0, `prdata` <= 0x00, go to IDLE.
- ACCESS with `psel`=0 or `pen`=0 before completion: abort. No write, `pready`/`prdata` cleared, go to IDLE.
- Back-to-back: a new setup cycle directly after completion is accepted from IDLE with no bubble beyond the APB setup cycle.
- The captured address and data are used. Changes on `paddr`/`pwdata` during ACCESS are ignored.
- Out-of-range address (>= NUM_REGS): the write is dropped, the read returns 0x00, and `wr_strobe` stays low.

## Timing
- Reset (`prst`=0, asynchronous): state IDLE, all registers 0x00, `pready`=0, `prdata`=0x00, `pslverr`=0, `wr_strobe`=0, `wr_idx`=0x00.
- Transfer length = 2 + WAIT_CYCLES cycles (setup + access). `pready` is registered and high for exactly one cycle per completed transfer.
- A read of a register written by the previous transfer returns the new value, because the commit precedes the next setup edge.
- Reset asserted mid-transfer: the transfer is discarded and any pending write is lost.

## Configuration
- `APB_REG_SLVERR_EN` defined: `pslverr` port exists. It is asserted alongside `pready` for an out-of-range address, or a write to register NUM_REGS-1 (read-only status register holding the count of aborted transfers, saturating at 0xFF). It is cleared with `pready`.
- Not defined: no `pslverr` port. Register NUM_REGS-1 is an ordinary read/write register and aborts are not counted.

## Structure
- Package `apb_reg_pkg`: ADDR_W=8, DATA_W=8, state enum (IDLE, ACCESS), WAIT counter width constant.
- Sub-module `apb_reg_bank`: register array with one synchronous write port (en, idx, data) and one combinational read mux. The FSM, wait counter and output registers live in the top.

## Test plan
- Reset, then read addr 0x03 with WAIT_CYCLES=0 -> `pready` high in the 2nd cycle, `prdata`=0x00.
- Write 0xA5 to 0x02, then read 0x02 -> `wr_strobe`=1 with `wr_idx`=0x02 on the completion edge; the read returns 0xA5.
- WAIT_CYCLES=3, write 0x5A to 0x01 -> `pready` low for 3 access cycles and high in the 4th; the transfer spans 5 cycles.
- Write to 0x40 with NUM_REGS=16 -> no `wr_strobe`; the read of 0x40 returns 0x00. With the macro, `pslverr`=1 alongside `pready`.
- Drop `psel` in the 2nd wait cycle of a write of 0x77 to 0x05 -> no commit, reg 5 still 0x00. With the macro, reg 15 reads 0x01.
- Assert `prst` during ACCESS of a write of 0x33 to 0x04 -> outputs go to 0 immediately and reg 4 reads 0x00 after release.
